fp_mult_iter: RTL and testbench
===============================

# fp_mult_iter

Iterative (shift-add) floating-point multiplier controller. It accepts one operand pair over a valid/ready handshake and classifies special cases first. A special result short-circuits to the output in 2 cycles. Otherwise it sequences a radix-2 mantissa multiply, normalisation and round-to-nearest-even, then holds the result until it is consumed. It is the area-optimised alternative to the pipelined multiplier for low-throughput clients.

## Interface
- `EXP_W`, default 8: exponent width.
- `MAN_W`, default 23: stored mantissa width. The hidden bit is implicit.
- `BIAS`, default 127: exponent bias.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept. High only in IDLE.
- `in_a` in 1+EXP_W+MAN_W: operand A, as {sign, exp, man}.
- `in_b` in 1+EXP_W+MAN_W: operand B.
- `out_valid` out 1: result valid. High only in DONE.
- `out_ready` in 1: consumer accepts the result.
- `out_res` out 1+EXP_W+MAN_W: product.
- `out_flags` out 4: {invalid, overflow, underflow, inexact}. Present only with `FP_MULT_ITER_FLAGS_EN`.

## Operation
States and transitions:
- IDLE: on `in_valid && in_ready`, capture operands and go to CLASS.
- CLASS: compute the sign of the result as A sign XOR B sign.
- CLASS, operand classes:
  - exp==0 is zero. Subnormal inputs are flushed to zero.
  - exp all-ones with man==0 is inf.
  - exp all-ones with man!=0 is NaN.
- CLASS, special-case priority (first match wins):
  1. NaN: any NaN input, inf×0, or 0×inf. Result is the canonical NaN: sign 0, exp all-ones, man = 1 followed by zeros. Sets invalid.
  2. Inf: either operand inf. Result is the signed inf.
  3. Zero: either operand zero. Result is the signed zero.
- CLASS, next state: any special case goes to DONE. Otherwise go to MULT, load the counter with MAN_W, and set the biased exponent to ea+eb−BIAS.
- Exponent arithmetic is signed, EXP_W+2 bits wide.
- MULT: one multiplier bit per cycle, LSB first, into a 2·(MAN_W+1)-bit accumulator.
  - The counter decrements each cycle.
  - Leave MULT after the cycle where counter==0, i.e. after MAN_W+1 cycles.
- NORM: if the product MSB is set, shift right 1 and increment the exponent.
  - Then take mantissa, guard and sticky, where sticky is the OR of all remaining low bits.
- ROUND: round to nearest, ties to even. A mantissa carry-out increments the exponent. Then apply, in this order:
  - exp ≥ 2^EXP_W−1: signed inf, with overflow and inexact set.
  - exp ≤ 0: signed zero (no subnormal output), with underflow and inexact set.
  - otherwise: normal result. inexact = guard OR sticky.
- DONE: `out_valid`=1. `out_res` and `out_flags` are stable while waiting.
  - On `out_ready`, go to IDLE.
  - `in_ready` stays 0 in DONE. There is no accept in the same cycle as result hand-off.
- `in_valid` is ignored outside IDLE, and operand changes after accept are ignored.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_res`=0, `out_flags`=0, counter 0.
- Accept edge = cycle 0.
- Special-case path: `out_valid` is high from cycle 2.
- Normal path: `out_valid` is high from cycle MAN_W+5, which is cycle 28 for the defaults.
- Back-pressure: DONE holds indefinitely and the outputs do not change.
- Minimum issue interval:
  - normal path: MAN_W+6 cycles (accept to next accept with `out_ready` tied high);
  - special-case path: 3 cycles.
- Reset asserted in any state: return to IDLE immediately and drop the in-flight operation with no output.

## Configuration
- `FP_MULT_ITER_FLAGS_EN` defined: the `out_flags` port and flag registers exist, with the behaviour above.
- Macro undefined: the port and registers are removed. `out_res` and timing are identical.

## Structure
- Shared package `fp_pkg` holds:
  - the state enum (IDLE, CLASS, MULT, NORM, ROUND, DONE);
  - flag bit index constants;
  - canonical-NaN / inf / zero constructor functions, parameterised on EXP_W/MAN_W.
- Sub-module `fp_mult_shift_add` is the accumulator/multiplicand register pair with a `step` enable. It holds no control logic.
- The FSM, counter, classify, normalise and round logic live in `fp_mult_iter`.

## Test plan
- Normal product: A=0x3FC00000 (1.5), B=0x40000000 (2.0) → `out_res`=0x40400000, flags 0, `out_valid` at cycle 28.
- Invalid: A=0x7F800000 (inf), B=0x00000000 → 0x7FC00000, invalid=1, `out_valid` at cycle 2.
- Overflow: A=B=0x7F000000 → 0x7F800000, overflow=1, inexact=1.
- Rounding and sign: A=B=0x3F800001 → 0x3F800002, inexact=1.
  - Then A=0xBF800000 (−1.0), B=0x3F800000 (1.0) → 0xBF800000.
- Back-pressure: hold `out_ready`=0 for 5 cycles in DONE → `out_res` stable, `in_ready`=0, and new `in_valid` is ignored. Result is released on the `out_ready` edge.
- Reset during MULT: pulse `rst_n` low at cycle 10 → `out_valid`=0 and `in_ready`=1 immediately. A subsequent 1.5×2.0 returns 0x40400000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the iterative floating-point multiplier:
// controller state encoding, flag bit positions and helpers that build
// special-value encodings for any exponent/mantissa width up to 64 bits.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLASS = 3'd1,
    MULT  = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Constructors return a 64-bit value; callers size-cast to 1+exp_w+man_w.
  localparam int FP_MAX_W = 64;

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  function automatic logic [FP_MAX_W-1:0] fp_nan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] r;
    r = ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1)) << man_w;
    r[man_w-1] = 1'b1;
    return r;
  endfunction

  // Signed infinity: exponent all ones, mantissa zero.
  function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w,
                                                 input int man_w);
    logic [FP_MAX_W-1:0] r;
    r = ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1)) << man_w;
    r[exp_w+man_w] = sign;
    return r;
  endfunction

  // Signed zero.
  function automatic logic [FP_MAX_W-1:0] fp_zero(input logic sign, input int exp_w,
                                                  input int man_w);
    logic [FP_MAX_W-1:0] r;
    r = '0;
    r[exp_w+man_w] = sign;
    return r;
  endfunction

endpackage

// File: rtl/fp_mult_shift_add.sv
// Radix-2 shift-add datapath: a multiplicand register and a 2N-bit
// accumulator whose low half initially holds the multiplier. Each step
// conditionally adds the multiplicand to the upper half (based on the
// current multiplier LSB) and shifts the whole accumulator right by one.
// After N steps the accumulator holds the full 2N-bit product.
module fp_mult_shift_add #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   mcand_in,
  input  logic [N-1:0]   mplier_in,
  output logic [2*N-1:0] acc
);

  logic [N-1:0] mcand_q;
  logic [N:0]   sum;

  // Partial-product add for the multiplier bit currently at acc[0]
  always_comb begin
    sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mcand_q} : '0);
  end

  // Load operands, or advance one multiplier bit per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc     <= '0;
    end else if (load) begin
      mcand_q <= mcand_in;
      acc     <= {{N{1'b0}}, mplier_in};
    end else if (step) begin
      acc <= {sum, acc[N-1:1]};
    end
  end

endmodule

// File: rtl/fp_mult_iter.sv
// Iterative floating-point multiplier controller. Special operands
// short-circuit from CLASS to DONE; everything else runs MAN_W+1
// shift-add steps, then a normalise and a round-to-nearest-even cycle.
// Subnormal inputs flush to zero and no subnormal results are produced.
// Optional macro FP_MULT_ITER_FLAGS_EN adds the out_flags port and its
// registers; out_res and timing are the same either way.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE, so an
// accept and a result hand-off never share a cycle; out_res is held until
// out_ready is seen.
module fp_mult_iter
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_res,
`ifdef FP_MULT_ITER_FLAGS_EN
  output logic [3:0]             out_flags,
`endif
  output state_t                 dbg_state
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int N     = MAN_W + 1;
  localparam int CNT_W = $clog2(MAN_W + 1);
  localparam logic signed [EXP_W+1:0] BIAS_X  = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

  state_t                   state_q, state_d;
  logic [W-1:0]             a_q, b_q, res_q, res_d;
  logic [CNT_W-1:0]         cnt_q;
  logic                     sign_q, guard_q, sticky_q;
  logic signed [EXP_W+1:0]  exp_q, exp_init, exp_rnd;
  logic [MAN_W-1:0]         man_q;
  logic [MAN_W:0]           man_rnd;
  logic [2*N-1:0]           prod;
  logic                     sign_c, round_up, ovf, unf;
  logic                     a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic                     is_nan, is_inf, is_zero, special;
`ifdef FP_MULT_ITER_FLAGS_EN
  logic [3:0]               flags_q, flags_d;
`endif

  fp_mult_shift_add #(.N(N)) u_shift_add (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state_q == CLASS),
    .step      (state_q == MULT),
    .mcand_in  ({1'b1, a_q[MAN_W-1:0]}),
    .mplier_in ({1'b1, b_q[MAN_W-1:0]}),
    .acc       (prod)
  );

  // Operand classification, special-case priority and rounding arithmetic
  always_comb begin
    a_zero   = (a_q[W-2:MAN_W] == '0);
    b_zero   = (b_q[W-2:MAN_W] == '0);
    a_inf    = (a_q[W-2:MAN_W] == '1) && (a_q[MAN_W-1:0] == '0);
    b_inf    = (b_q[W-2:MAN_W] == '1) && (b_q[MAN_W-1:0] == '0);
    a_nan    = (a_q[W-2:MAN_W] == '1) && (a_q[MAN_W-1:0] != '0);
    b_nan    = (b_q[W-2:MAN_W] == '1) && (b_q[MAN_W-1:0] != '0);
    is_nan   = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
    is_inf   = a_inf || b_inf;
    is_zero  = a_zero || b_zero;
    special  = is_nan || is_inf || is_zero;
    sign_c   = a_q[W-1] ^ b_q[W-1];
    exp_init = $signed({2'b00, a_q[W-2:MAN_W]}) + $signed({2'b00, b_q[W-2:MAN_W]}) - BIAS_X;
    round_up = guard_q && (sticky_q || man_q[0]);
    man_rnd  = {1'b0, man_q} + {{MAN_W{1'b0}}, round_up};
    exp_rnd  = exp_q + {{(EXP_W+1){1'b0}}, man_rnd[MAN_W]};
    ovf      = (exp_rnd >= EXP_MAX);
    unf      = exp_rnd[EXP_W+1] || (exp_rnd == '0);
  end

  // Result and flag values produced by CLASS (special cases) and ROUND
  always_comb begin
    res_d = res_q;
`ifdef FP_MULT_ITER_FLAGS_EN
    flags_d = flags_q;
`endif
    if (state_q == CLASS && special) begin
`ifdef FP_MULT_ITER_FLAGS_EN
      flags_d = '0;
      flags_d[FLAG_INVALID] = is_nan;
`endif
      if (is_nan)      res_d = W'(fp_nan(EXP_W, MAN_W));
      else if (is_inf) res_d = W'(fp_inf(sign_c, EXP_W, MAN_W));
      else             res_d = W'(fp_zero(sign_c, EXP_W, MAN_W));
    end else if (state_q == ROUND) begin
`ifdef FP_MULT_ITER_FLAGS_EN
      flags_d = '0;
      flags_d[FLAG_OVERFLOW]  = ovf;
      flags_d[FLAG_UNDERFLOW] = !ovf && unf;
      flags_d[FLAG_INEXACT]   = ovf || unf || guard_q || sticky_q;
`endif
      if (ovf)      res_d = W'(fp_inf(sign_q, EXP_W, MAN_W));
      else if (unf) res_d = W'(fp_zero(sign_q, EXP_W, MAN_W));
      else          res_d = {sign_q, exp_rnd[EXP_W-1:0], man_rnd[MAN_W-1:0]};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CLASS;
      end
      CLASS:   state_d = special ? DONE : MULT;
      MULT:    if (cnt_q == '0) state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, step counter, exponent and normalised mantissa fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      cnt_q    <= '0;
      man_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q <= in_a;
          b_q <= in_b;
        end
        CLASS: begin
          sign_q <= sign_c;
          exp_q  <= exp_init;
          cnt_q  <= CNT_W'(MAN_W);
        end
        MULT: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        NORM: begin
          // Product lies in [1,4); a set MSB means one extra right shift
          exp_q <= exp_q + {{(EXP_W+1){1'b0}}, prod[2*N-1]};
          if (prod[2*N-1]) begin
            man_q    <= prod[2*MAN_W:MAN_W+1];
            guard_q  <= prod[MAN_W];
            sticky_q <= |prod[MAN_W-1:0];
          end else begin
            man_q    <= prod[2*MAN_W-1:MAN_W];
            guard_q  <= prod[MAN_W-1];
            sticky_q <= |prod[MAN_W-2:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Result (and flag) registers, held stable through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
`ifdef FP_MULT_ITER_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      res_q   <= res_d;
`ifdef FP_MULT_ITER_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

  assign out_res   = res_q;
  assign dbg_state = state_q;
`ifdef FP_MULT_ITER_FLAGS_EN
  assign out_flags = flags_q;
`endif

endmodule

// File: tb/tb_fp_mult_iter.sv
// Directed bench for fp_mult_iter (single precision defaults). Expected
// results, flags and latencies are queued when an operand pair is issued
// and popped when the result appears. Flag checks are compiled in only
// when FP_MULT_ITER_FLAGS_EN is defined.
module tb_fp_mult_iter;
  import fp_pkg::*;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_res;
  state_t       dbg_state;
`ifdef FP_MULT_ITER_FLAGS_EN
  logic [3:0]   out_flags;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_flags_q[$];
  int           exp_lat_q[$];

  fp_mult_iter #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(BIAS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
`ifdef FP_MULT_ITER_FLAGS_EN
    .out_flags (out_flags),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- comparison ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Integer reference: exact 48-bit product, remainder-based RNE.
  // Only used for operands whose result stays in the normal range.
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           output logic inexact);
    longint unsigned pa, pb, p, m, rem, half;
    int e, sh;
    pa = {40'd0, 1'b1, a[22:0]};
    pb = {40'd0, 1'b1, b[22:0]};
    p  = pa * pb;
    e  = int'(a[30:23]) + int'(b[30:23]) - BIAS;
    sh = ((p >> 47) != 0) ? 24 : 23;
    if (sh == 24) e++;
    m    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    inexact = (rem != 0);
    if (rem > half || (rem == half && m[0])) m++;
    if ((m >> 24) != 0) begin
      m = m >> 1;
      e++;
    end
    return {a[31] ^ b[31], e[7:0], m[22:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Present one operand pair; returns one time step after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic [3:0] f, input int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue_ready", W'(in_ready), W'(1));
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    exp_q.push_back(r);
    exp_flags_q.push_back(f);
    exp_lat_q.push_back(lat);
    @(posedge clk); #1;
    // Operand changes after the accept must not matter
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
  endtask

  // Wait for the result, compare against the queue, optionally stall
  // out_ready for 'hold' cycles while poking in_valid, then release.
  task automatic collect(input int hold);
    int n;
    logic [W-1:0] r;
    logic [3:0]   f;
    int           lat;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    r   = exp_q.pop_front();
    f   = exp_flags_q.pop_front();
    lat = exp_lat_q.pop_front();
    check("out_valid", W'(out_valid), W'(1));
    check("latency", W'(n + 1), W'(lat));
    check("out_res", out_res, r);
`ifdef FP_MULT_ITER_FLAGS_EN
    check("out_flags", W'(out_flags), W'(f));
`endif
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_a = $urandom;
      in_b = $urandom;
      @(posedge clk); #1;
      check("hold_res", out_res, r);
      check("hold_valid", W'(out_valid), W'(1));
      check("hold_in_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    // in_valid may still be high here: the hand-off edge must not accept
    check("release_valid", W'(out_valid), W'(0));
    check("release_state", W'(dbg_state), W'(IDLE));
    in_valid = 1'b0;
  endtask

  // Accept-to-accept distance with in_valid and out_ready held high.
  task automatic interval(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_gap);
    int n, gap;
    out_ready = 1'b1;
    in_a = a;
    in_b = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    gap = 1;
    while (!in_ready && gap < 100) begin
      @(posedge clk); #1;
      gap++;
    end
    check(tag, W'(gap), W'(exp_gap));
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] ra, rb, rr;
    logic         inx;
    logic [7:0]   ea, eb;

    // Reset state
    #12;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_res", out_res, '0);
    check("rst_state", W'(dbg_state), W'(IDLE));
`ifdef FP_MULT_ITER_FLAGS_EN
    check("rst_flags", W'(out_flags), '0);
`endif
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Test-plan vectors
    issue(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 28); collect(0);
    issue(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 2);  collect(0);
    issue(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 28); collect(0);
    issue(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 28); collect(5);
    issue(32'hBF800000, 32'h3F800000, 32'hBF800000, 4'b0000, 28); collect(0);

    // Further special cases and the underflow boundary
    issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2);  collect(0);
    issue(32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000, 2);  collect(0);
    issue(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2);  collect(0);
    issue(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 2);  collect(0);
    issue(32'h00000001, 32'hBF800000, 32'h80000000, 4'b0000, 2);  collect(0);
    issue(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 28); collect(0);
    issue(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, 28); collect(0);

    // Reset during MULT drops the operation
    in_valid = 1'b1;
    in_a = 32'h3FC00000;
    in_b = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("pre_rst_state", W'(dbg_state), W'(MULT));
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", W'(in_ready), W'(1));
    check("mid_rst_out_valid", W'(out_valid), W'(0));
    check("mid_rst_state", W'(dbg_state), W'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("post_rst_out_valid", W'(out_valid), W'(0));
    issue(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 28); collect(0);

    // Random normal-range operands against the integer reference
    for (int i = 0; i < 6; i++) begin
      ea = 8'($urandom_range(100, 150));
      eb = 8'($urandom_range(100, 150));
      ra = {1'($urandom_range(0, 1)), ea, 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), eb, 23'($urandom)};
      rr = ref_mul(ra, rb, inx);
      issue(ra, rb, rr, {3'b000, inx}, 28);
      collect($urandom_range(0, 2));
    end

    // Minimum issue interval
    interval("gap_special", 32'h7F800000, 32'h00000000, 3);
    interval("gap_normal", 32'h3FC00000, 32'h40000000, MAN_W + 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
